// File: rtl/sar_pkg.sv
// Shared types and helpers for the SAR ADC controller: FSM state encoding
// and a constant-evaluable ceil(log2) used to size the bit index and counters.
package sar_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SMP  = 3'd1,
    TRY  = 3'd2,
    DEC  = 3'd3,
    FIN  = 3'd4
  } state_t;

  // Smallest w with (1 << w) >= n; returns at least 1 so indices never collapse to 0 bits.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/sar_succ_reg.sv
// Successive-approximation trial/decision register: loads the MSB trial,
// resolves bit idx from the comparator while seeding bit idx-1, or clears.
module sar_succ_reg
  import sar_pkg::*;
#(
  parameter int N_BITS = 8,
  localparam int IDX_W = clog2(N_BITS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              resolve,
  input  logic              clear,
  input  logic              cmp,
  input  logic [IDX_W-1:0]  idx,
  output logic [N_BITS-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      q <= '0;
    end else if (load) begin
      q <= '0;
      q[N_BITS-1] <= 1'b1;
    end else if (resolve) begin
      q[idx] <= cmp;
      // Seed the next lower trial bit in the same edge so TRY sees a settled code.
      if (idx != '0) q[idx - 1'b1] <= 1'b1;
    end
  end

endmodule

// File: rtl/sar_adc_ctrl.sv
// SAR ADC sequencer: sample, per-bit trial/decide, result capture with DONE pulse.
// Optional back-to-back conversions when SAR_CONTINUOUS_EN is defined (adds CONT input).
module sar_adc_ctrl
  import sar_pkg::*;
#(
  parameter int N_BITS        = 8,
  parameter int SAMPLE_CYCLES = 2
) (
  input  logic              CK,
  input  logic              R,
`ifdef SAR_CONTINUOUS_EN
  input  logic              CONT,
`endif
  input  logic              START,
  input  logic              CMP,
  output logic              SAMPLE,
  output logic              CMP_EN,
  output logic [N_BITS-1:0] DAC,
  output logic [N_BITS-1:0] DOUT,
  output logic              DONE,
  output logic              BUSY
);

  localparam int IDX_W = clog2(N_BITS);
  localparam int CNT_W = clog2(SAMPLE_CYCLES + 1);
  localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(N_BITS - 1);
  localparam logic [CNT_W-1:0] SMP_LAST = CNT_W'(SAMPLE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             cont_go;
  logic             reg_load;
  logic             reg_resolve;
  logic             reg_clear;

`ifdef SAR_CONTINUOUS_EN
  assign cont_go = CONT;
`else
  assign cont_go = 1'b0;
`endif

  always_comb begin
    reg_load    = 1'b0;
    reg_resolve = 1'b0;
    reg_clear   = 1'b0;
    if (state == SMP && cnt == SMP_LAST) reg_load = 1'b1;
    if (state == DEC) reg_resolve = 1'b1;
    if (state == FIN) reg_clear = 1'b1;
  end

  sar_succ_reg #(.N_BITS(N_BITS)) u_succ_reg (
    .clk     (CK),
    .rst     (R),
    .load    (reg_load),
    .resolve (reg_resolve),
    .clear   (reg_clear),
    .cmp     (CMP),
    .idx     (idx),
    .q       (DAC)
  );

  always_ff @(posedge CK) begin
    if (R) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      SAMPLE <= 1'b0;
      CMP_EN <= 1'b0;
      DOUT   <= '0;
      DONE   <= 1'b0;
      BUSY   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            state  <= SMP;
            cnt    <= '0;
            SAMPLE <= 1'b1;
            BUSY   <= 1'b1;
          end
        end
        SMP: begin
          if (cnt == SMP_LAST) begin
            state  <= TRY;
            SAMPLE <= 1'b0;
            idx    <= IDX_MSB;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TRY: begin
          state  <= DEC;
          CMP_EN <= 1'b1;
        end
        DEC: begin
          CMP_EN <= 1'b0;
          if (idx != '0) begin
            idx   <= idx - 1'b1;
            state <= TRY;
          end else begin
            // Capture with the LSB decision folded in so DOUT is valid alongside DONE.
            state <= FIN;
            DOUT  <= {DAC[N_BITS-1:1], CMP};
            DONE  <= 1'b1;
          end
        end
        FIN: begin
          if (cont_go) begin
            state  <= SMP;
            cnt    <= '0;
            SAMPLE <= 1'b1;
          end else begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Bench for sar_adc_ctrl: comparator model driven from VIN, expected results
// queued at stimulus time and checked by a DONE-triggered monitor.
module tb_sar_adc_ctrl;

  localparam int N  = 8;
  localparam int LAT = 19;  // 2 sample + 16 trial/decide + 1 finish

  logic         CK;
  logic         R;
  logic         START;
  logic         CMP;
  logic         SAMPLE;
  logic         CMP_EN;
  logic [N-1:0] DAC;
  logic [N-1:0] DOUT;
  logic         DONE;
  logic         BUSY;
`ifdef SAR_CONTINUOUS_EN
  logic         CONT;
`endif

  logic [N-1:0] vin;
  logic         junk;
  int           tests;
  int           fails;
  int           done_count;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] trials_a5 [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

  sar_adc_ctrl #(.N_BITS(N), .SAMPLE_CYCLES(2)) dut (
    .CK     (CK),
    .R      (R),
`ifdef SAR_CONTINUOUS_EN
    .CONT   (CONT),
`endif
    .START  (START),
    .CMP    (CMP),
    .SAMPLE (SAMPLE),
    .CMP_EN (CMP_EN),
    .DAC    (DAC),
    .DOUT   (DOUT),
    .DONE   (DONE),
    .BUSY   (BUSY)
  );

  // Clock and comparator model; outside the strobe CMP toggles to prove it is ignored.
  initial CK = 1'b0;
  always #5 CK = ~CK;
  initial junk = 1'b0;
  always @(negedge CK) junk <= ~junk;
  assign CMP = CMP_EN ? (vin >= DAC) : junk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge CK) begin
    if (DONE) begin
      done_count++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got DOUT 0x%0h expected no DONE", DOUT);
      end else begin
        check("dout", {24'h0, DOUT}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  // Steps negedges until DONE or budget; reports cycles stepped and whether BUSY dropped.
  task automatic wait_done(input int budget, output int cyc, output bit busy_low);
    cyc = 0;
    busy_low = 1'b0;
    while (!DONE && cyc < budget) begin
      @(negedge CK);
      cyc++;
      if (!BUSY) busy_low = 1'b1;
    end
    if (!DONE) check("done_timeout", 32'h0, 32'h1);
  endtask

  // One pulsed conversion with latency, sample-phase and post-finish checks.
  task automatic run_conv(input logic [N-1:0] v, input bit trace);
    int c;
    int t;
    int done_c;
    vin = v;
    exp_q.push_back(v);
    @(negedge CK);
    START = 1'b1;
    @(negedge CK);
    START = 1'b0;
    c = 1;
    t = 0;
    done_c = 0;
    while (c <= 40 && done_c == 0) begin
      if (trace && c <= 3) check($sformatf("sample_c%0d", c), {31'h0, SAMPLE}, {31'h0, c <= 2});
      if (trace && CMP_EN) begin
        if (t < 8) check($sformatf("trial_%0d", t), {24'h0, DAC}, {24'h0, trials_a5[t]});
        t++;
      end
      if (DONE) done_c = c;
      else begin
        @(negedge CK);
        c++;
      end
    end
    check("latency", done_c, LAT);
    @(negedge CK);
    check("dac_after_fin", {24'h0, DAC}, 32'h0);
    check("busy_after_fin", {31'h0, BUSY}, 32'h0);
  endtask

  initial begin
    int c1;
    int c2;
    int d0;
    bit bl;
    tests = 0;
    fails = 0;
    done_count = 0;
    R = 1'b1;
    START = 1'b0;
    vin = '0;
`ifdef SAR_CONTINUOUS_EN
    CONT = 1'b0;
`endif
    repeat (3) @(negedge CK);
    check("rst_sample", {31'h0, SAMPLE}, 32'h0);
    check("rst_cmp_en", {31'h0, CMP_EN}, 32'h0);
    check("rst_dac", {24'h0, DAC}, 32'h0);
    check("rst_dout", {24'h0, DOUT}, 32'h0);
    check("rst_done", {31'h0, DONE}, 32'h0);
    check("rst_busy", {31'h0, BUSY}, 32'h0);
    R = 1'b0;
    @(negedge CK);

    // Mid-scale code with full trial trace.
    run_conv(8'hA5, 1'b1);

    // Rails.
    run_conv(8'h00, 1'b0);
    run_conv(8'hFF, 1'b0);

    // START pulses at cycles 5 and 10 of a conversion are ignored.
    d0 = done_count;
    fork
      run_conv(8'h3A, 1'b0);
      begin
        repeat (6) @(negedge CK);
        START = 1'b1;
        @(negedge CK);
        START = 1'b0;
        repeat (4) @(negedge CK);
        START = 1'b1;
        @(negedge CK);
        START = 1'b0;
      end
    join
    repeat (25) @(negedge CK);
    check("single_done", done_count - d0, 1);
    check("idle_after_ignored", {31'h0, BUSY}, 32'h0);

    // Reset during the bit-4 decide phase aborts cleanly.
    vin = 8'hF0;
    @(negedge CK);
    START = 1'b1;
    @(negedge CK);
    START = 1'b0;
    repeat (9) @(negedge CK);
    check("pre_abort_cmp_en", {31'h0, CMP_EN}, 32'h1);
    R = 1'b1;
    @(negedge CK);
    R = 1'b0;
    check("abort_sample", {31'h0, SAMPLE}, 32'h0);
    check("abort_cmp_en", {31'h0, CMP_EN}, 32'h0);
    check("abort_dac", {24'h0, DAC}, 32'h0);
    check("abort_dout", {24'h0, DOUT}, 32'h0);
    check("abort_busy", {31'h0, BUSY}, 32'h0);
    run_conv(8'h5A, 1'b0);

    // START held high: FIN, one IDLE cycle, then the next conversion.
    @(negedge CK);
    vin = 8'h3C;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    START = 1'b1;
    wait_done(40, c1, bl);
    check("held_first_latency", c1, LAT);
    vin = 8'hC3;
    @(negedge CK);
    wait_done(40, c2, bl);
    check("held_interval", c2 + 1, LAT + 1);
    START = 1'b0;
    repeat (3) @(negedge CK);
    check("held_idle", {31'h0, BUSY}, 32'h0);

`ifdef SAR_CONTINUOUS_EN
    // Continuous mode: DONE every 19 cycles with BUSY held.
    vin = 8'h77;
    repeat (3) exp_q.push_back(8'h77);
    CONT = 1'b1;
    START = 1'b1;
    @(negedge CK);
    START = 1'b0;
    wait_done(40, c1, bl);
    check("cont_first_latency", c1 + 1, LAT);
    for (int k = 0; k < 2; k++) begin
      if (k == 1) CONT = 1'b0;
      @(negedge CK);
      wait_done(40, c2, bl);
      check("cont_interval", c2 + 1, LAT);
      check("cont_busy_held", {31'h0, bl}, 32'h0);
    end
    repeat (3) @(negedge CK);
    check("cont_stop_idle", {31'h0, BUSY}, 32'h0);
`endif

    repeat (3) @(negedge CK);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
